// File: rtl/pdm_capture_sequencer.sv
// Capture/TX sequencer between the PDM write path, TX FIFO and SPI slave.
// Optional build macro: PDM_CAPTURE_SEQ_OVERFLOW_STOP_EN (capture ends on FIFO overflow).
module pdm_capture_sequencer #(
  parameter int                    FIFO_WIDTH    = 8,
  parameter int                    COUNT_WIDTH   = 20,
  parameter int                    CAPTURE_LIMIT = 524288,
  parameter logic [FIFO_WIDTH-1:0] FILL_BYTE     = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   spi_busy,
  input  logic                   spi_rx_valid,
  input  logic [7:0]             spi_rx_data,
  output logic [FIFO_WIDTH-1:0]  spi_tx_data,
  output logic                   spi_tx_valid,
  input  logic                   sample_wr,
  output logic                   fifo_wr_en,
  output logic                   fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_empty,
  input  logic                   fifo_full,
  output logic                   capture_en,
  output logic [COUNT_WIDTH-1:0] byte_count
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;
  typedef enum logic [1:0] {M_STATUS, M_STREAM, M_FILL} mode_t;

  localparam bit                     LIMIT_EN = (CAPTURE_LIMIT != 0);
  localparam logic [COUNT_WIDTH-1:0] LIMIT_C  = COUNT_WIDTH'(CAPTURE_LIMIT);

  state_t                 r_state;
  state_t                 w_state_next;
  mode_t                  r_mode;
  mode_t                  w_mode_next;
  logic [2:0]             r_busy_sync;
  logic [COUNT_WIDTH-1:0] r_byte_count;
  logic                   r_overflow;
  logic                   r_underrun;
  logic                   r_ld_p0;
  logic                   r_ld_p1;
  logic                   r_src_fifo_p0;
  logic                   r_src_fifo_p1;
  logic [FIFO_WIDTH-1:0]  r_pad_p0;
  logic [FIFO_WIDTH-1:0]  r_pad_p1;
  logic                   r_rd_en;
  logic                   r_tx_valid;
  logic [FIFO_WIDTH-1:0]  r_tx_data;

  logic                   w_cmd_start;
  logic                   w_cmd_stop;
  logic                   w_cmd_clear;
  logic                   w_capture;
  logic                   w_wr_en;
  logic [COUNT_WIDTH-1:0] w_count_inc;
  logic                   w_count_max;
  logic                   w_limit_hit;
  logic                   w_ovf_event;
  logic                   w_ovf_stop;
  logic                   w_busy_edge;
  logic                   w_edge_take;
  logic                   w_fetch;
  logic                   w_underrun_event;
  logic                   w_status_load;
  logic [FIFO_WIDTH-1:0]  w_status;
  logic [FIFO_WIDTH-1:0]  w_pad_byte;

  assign w_cmd_start = spi_rx_valid && (spi_rx_data == 8'h01);
  assign w_cmd_stop  = spi_rx_valid && (spi_rx_data == 8'h02);
  assign w_cmd_clear = spi_rx_valid && (spi_rx_data == 8'h00);

  assign w_capture   = (r_state == S_CAPTURE);
  assign w_wr_en     = sample_wr & w_capture & ~fifo_full;
  assign w_count_inc = r_byte_count + COUNT_WIDTH'(1);
  assign w_count_max = &r_byte_count;
  // A START on the same edge restarts the count, so that write must not end the capture.
  assign w_limit_hit = LIMIT_EN && w_wr_en && (w_count_inc == LIMIT_C) && !w_cmd_start;
  assign w_ovf_event = w_capture & sample_wr & fifo_full;

`ifdef PDM_CAPTURE_SEQ_OVERFLOW_STOP_EN
  assign w_ovf_stop = w_ovf_event;
`else
  assign w_ovf_stop = 1'b0;
`endif

  always_comb begin
    w_mode_next = r_mode;
    if (spi_rx_valid) begin
      case (spi_rx_data)
        8'h03:   w_mode_next = M_STATUS;
        8'h04:   w_mode_next = M_STREAM;
        8'h05:   w_mode_next = M_FILL;
        default: w_mode_next = r_mode;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    w_state_next = S_IDLE;
      S_CAPTURE: if (w_cmd_stop || w_limit_hit || w_ovf_stop) w_state_next = S_DONE;
      S_DONE:    if (w_cmd_clear) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
    if (w_cmd_start) w_state_next = S_CAPTURE;
  end

  // Busy edges use the mode after any same-cycle command; edges during a fetch are dropped.
  assign w_busy_edge      = r_busy_sync[1] & ~r_busy_sync[2];
  assign w_edge_take      = w_busy_edge & ~(r_ld_p0 | r_ld_p1);
  assign w_fetch          = w_edge_take & (w_mode_next == M_STREAM) & ~fifo_empty;
  assign w_underrun_event = w_edge_take & (w_mode_next == M_STREAM) & fifo_empty;
  assign w_status_load    = w_edge_take & (w_mode_next == M_STATUS);

  always_comb begin
    w_status      = '0;
    w_status[7:2] = {w_capture, (r_state == S_DONE), r_overflow, r_underrun,
                     fifo_empty, fifo_full};
  end

  assign w_pad_byte = (w_mode_next == M_STATUS) ? w_status : FILL_BYTE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_mode       <= M_FILL;
      r_busy_sync  <= 3'b000;
      r_byte_count <= '0;
      r_overflow   <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_mode      <= w_mode_next;
      r_busy_sync <= {r_busy_sync[1:0], spi_busy};
      if (w_cmd_start)
        r_byte_count <= '0;
      else if (w_wr_en && !w_count_max)
        r_byte_count <= w_count_inc;
      if (w_ovf_event && !w_cmd_start)
        r_overflow <= 1'b1;
      else if (w_cmd_start || w_status_load)
        r_overflow <= 1'b0;
      if (w_underrun_event)
        r_underrun <= 1'b1;
      else if (w_status_load)
        r_underrun <= 1'b0;
    end
  end

  // Stage p0: FIFO pop issued; stage p1: FIFO data present; then load into the TX register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_p0       <= 1'b0;
      r_ld_p1       <= 1'b0;
      r_src_fifo_p0 <= 1'b0;
      r_src_fifo_p1 <= 1'b0;
      r_rd_en       <= 1'b0;
      r_tx_valid    <= 1'b0;
      r_tx_data     <= FILL_BYTE;
    end else begin
      r_ld_p0       <= w_edge_take;
      r_src_fifo_p0 <= w_fetch;
      r_rd_en       <= w_fetch;
      r_ld_p1       <= r_ld_p0;
      r_src_fifo_p1 <= r_src_fifo_p0;
      r_tx_valid    <= r_ld_p1;
      if (r_ld_p1)
        r_tx_data <= r_src_fifo_p1 ? fifo_rd_data : r_pad_p1;
    end
  end

  always_ff @(posedge clk) begin
    r_pad_p0 <= w_pad_byte;
    r_pad_p1 <= r_pad_p0;
  end

  assign fifo_wr_en   = w_wr_en;
  assign fifo_rd_en   = r_rd_en;
  assign spi_tx_valid = r_tx_valid;
  assign spi_tx_data  = r_tx_data;
  assign capture_en   = w_capture;
  assign byte_count   = r_byte_count;

endmodule

// File: tb/tb_pdm_capture_sequencer.sv
// Scoreboard bench for pdm_capture_sequencer: directed scenarios plus a randomized command/write/busy mix.
module tb_pdm_capture_sequencer;
  localparam int         LIMIT = 16;
  localparam logic [7:0] FILL  = 8'hC3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        spi_busy = 1'b0;
  logic        spi_rx_valid = 1'b0;
  logic [7:0]  spi_rx_data = 8'h00;
  logic [7:0]  spi_tx_data;
  logic        spi_tx_valid;
  logic        sample_wr = 1'b0;
  logic        fifo_wr_en;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic        fifo_empty = 1'b1;
  logic        fifo_full = 1'b0;
  logic        capture_en;
  logic [19:0] byte_count;

  pdm_capture_sequencer #(
    .FIFO_WIDTH(8), .COUNT_WIDTH(20), .CAPTURE_LIMIT(LIMIT), .FILL_BYTE(FILL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .spi_busy(spi_busy),
    .spi_rx_valid(spi_rx_valid), .spi_rx_data(spi_rx_data),
    .spi_tx_data(spi_tx_data), .spi_tx_valid(spi_tx_valid),
    .sample_wr(sample_wr), .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .capture_en(capture_en), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // TX FIFO stand-in: registered read data, empty flag follows the queue.
  logic [7:0] fifo_q[$];
  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() != 0) fifo_rd_data <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0);
  end

  typedef struct {logic [7:0] data; int at;} tx_exp_t;
  tx_exp_t txq[$];
  int      rdq[$];
  int      checks = 0;
  int      passed = 0;
  int      wr_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) if (rst_n && fifo_wr_en) wr_seen <= wr_seen + 1;

  always @(negedge clk) begin : monitor
    tx_exp_t e;
    int      r;
    if (rst_n && spi_tx_valid) begin
      if (txq.size() == 0) chk("tx_unexpected", {31'd0, spi_tx_valid}, 32'd0);
      else begin
        e = txq.pop_front();
        chk("tx_data", {24'd0, spi_tx_data}, {24'd0, e.data});
        chk("tx_cycle", cyc, e.at);
      end
    end
    if (rst_n && fifo_rd_en) begin
      if (rdq.size() == 0) chk("rd_unexpected", {31'd0, fifo_rd_en}, 32'd0);
      else begin
        r = rdq.pop_front();
        chk("rd_cycle", cyc, r);
      end
    end
  end

  // Reference model: 0 idle / 1 capture / 2 done; mode 0 status / 1 stream / 2 fill.
  int m_state = 0, m_mode = 2, m_count = 0, m_wr = 0;
  bit m_ovf = 0, m_und = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_state = 0; m_mode = 2; m_count = 0; m_ovf = 0; m_und = 0;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    spi_rx_valid = 1'b1;
    spi_rx_data  = b;
    @(negedge clk);
    spi_rx_valid = 1'b0;
    case (b)
      8'h00: if (m_state == 2) m_state = 0;
      8'h01: begin m_state = 1; m_count = 0; m_ovf = 0; end
      8'h02: if (m_state == 1) m_state = 2;
      8'h03: m_mode = 0;
      8'h04: m_mode = 1;
      8'h05: m_mode = 2;
      default: ;
    endcase
    chk("capture_en_after_cmd", {31'd0, capture_en}, {31'd0, m_state == 1});
  endtask

  task automatic write_n(input int n, input bit full);
    fifo_full = full;
    for (int i = 0; i < n; i++) begin
      sample_wr = 1'b1;
      if (m_state == 1) begin
        if (full) begin
          m_ovf = 1;
`ifdef PDM_CAPTURE_SEQ_OVERFLOW_STOP_EN
          m_state = 2;
`endif
        end else begin
          m_wr++;
          m_count++;
          if (m_count == LIMIT) m_state = 2;
        end
      end
      @(negedge clk);
    end
    sample_wr = 1'b0;
    fifo_full = 1'b0;
    tick(1);
    chk("byte_count", {12'd0, byte_count}, m_count);
    chk("wr_pulses", wr_seen, m_wr);
    chk("capture_en", {31'd0, capture_en}, {31'd0, m_state == 1});
  endtask

  task automatic push_fifo(input logic [7:0] b);
    fifo_q.push_back(b);
    tick(2);
  endtask

  // Valid is due five rising edges after busy is driven: two sync stages, detect, pop, load.
  task automatic busy_txn();
    logic [7:0] b;
    int         c;
    c = cyc;
    case (m_mode)
      1: if (fifo_q.size() != 0) begin b = fifo_q[0]; rdq.push_back(c + 3); end
         else begin b = FILL; m_und = 1; end
      0: begin
        b = {m_state == 1, m_state == 2, m_ovf, m_und, fifo_q.size() == 0, fifo_full, 2'b00};
        m_ovf = 0;
        m_und = 0;
      end
      default: b = FILL;
    endcase
    txq.push_back('{b, c + 5});
    spi_busy = 1'b1;
    tick(6);
    spi_busy = 1'b0;
    tick(4);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int c;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_tx_data", {24'd0, spi_tx_data}, {24'd0, FILL});
    chk("rst_tx_valid", {31'd0, spi_tx_valid}, 32'd0);
    chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("rst_capture_en", {31'd0, capture_en}, 32'd0);
    chk("rst_byte_count", {12'd0, byte_count}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    send_cmd(8'h01);
    write_n(10, 1'b0);
    send_cmd(8'h01);
    write_n(20, 1'b0);

    send_cmd(8'h04);
    push_fifo(8'hA5);
    push_fifo(8'h3C);
    busy_txn();
    busy_txn();
    busy_txn();
    send_cmd(8'h03);
    busy_txn();
    busy_txn();

    send_cmd(8'h01);
    write_n(1, 1'b1);
    send_cmd(8'h03);
    fifo_full = 1'b1;
    busy_txn();
    fifo_full = 1'b0;
    send_cmd(8'h05);
    busy_txn();

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0: send_cmd(8'($urandom_range(0, 9)));
        1: write_n($urandom_range(0, 6), $urandom_range(0, 3) == 0);
        2: busy_txn();
        3: push_fifo(8'($urandom));
        default: send_cmd(8'($urandom_range(1, 5)));
      endcase
    end

    // Abort a fetch between the pop and the TX load.
    send_cmd(8'h01);
    send_cmd(8'h04);
    push_fifo(8'h77);
    c = cyc;
    rdq.push_back(c + 3);
    spi_busy = 1'b1;
    while (cyc < c + 4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_tx_data", {24'd0, spi_tx_data}, {24'd0, FILL});
    chk("abort_tx_valid", {31'd0, spi_tx_valid}, 32'd0);
    chk("abort_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("abort_capture_en", {31'd0, capture_en}, 32'd0);
    chk("abort_byte_count", {12'd0, byte_count}, 32'd0);
    spi_busy = 1'b0;
    tick(4);
    rst_n = 1'b1;
    model_reset();
    tick(12);
    chk("post_abort_capture_en", {31'd0, capture_en}, 32'd0);

    send_cmd(8'h03);
    busy_txn();

    chk("tx_queue_drained", txq.size(), 32'd0);
    chk("rd_queue_drained", rdq.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
